// File: rtl/pattern_gen.sv
// pattern_gen: serial pattern transmitter.
// On an accepted start, shifts a W-bit pattern out MSB-first, once per clock,
// repeated `reps` times with GAP idle cycles between repetitions.
// Ports:
//   clk   - clock, rising edge
//   rst_b - asynchronous active-low reset
//   start - transmit request, sampled only in IDLE
//   pat   - pattern (bit W-1 first), latched on accepted start
//   reps  - repetition count, latched on accepted start (0 = request ignored)
//   o     - serial data (IDLE_LVL when no pattern bit is being sent)
//   valid - high while o carries a pattern bit
//   busy  - high in SEND and GAP
//   done  - one-cycle pulse after the final bit
module pattern_gen #(
    parameter int   W        = 4,
    parameter int   CW       = 4,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [W-1:0]  pat,
    input  logic [CW-1:0] reps,
    output logic          o,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(W);
    // gap_cnt needs at least one bit even when no gap state is ever entered
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rep_cnt_d = rep_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && (reps != '0)) begin
                    pat_d     = pat;
                    shreg_d   = pat;
                    rep_cnt_d = reps;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                shreg_d   = {shreg_q[W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - CW'(1);
                    end
                    bit_cnt_d = '0;
                    if (rep_cnt_q <= CW'(1)) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        // back-to-back: reload now so the next bit follows without a bubble
                        shreg_d = pat_q;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    shreg_d   = pat_q;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o     = (state_q == S_SEND) ? shreg_q[W-1] : IDLE_LVL;
        valid = (state_q == S_SEND);
        busy  = (state_q == S_SEND) || (state_q == S_GAP);
        done  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard bench for pattern_gen.
// Three configurations run side by side: (W=4,GAP=1,IDLE=1), (W=8,GAP=1,IDLE=0),
// (W=4,GAP=0,IDLE=1). For each accepted request the stimulus side expands the
// whole expected output trace (one entry per busy/done cycle, tagged with the
// clock edge it follows) into a queue; a monitor pops and compares whenever the
// DUT shows busy or done, and checks idle levels otherwise.
module tb_pattern_gen;

    typedef struct {
        int   cyc;
        logic o;
        logic v;
        logic b;
        logic d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index of the most recent rising edge
    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d t=%0t actual=%0h expected=%0h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int   W  = (g == 1) ? 8 : 4;
        localparam int   GP = (g == 2) ? 0 : 1;
        localparam logic IL = (g == 1) ? 1'b0 : 1'b1;

        logic         rst_b;
        logic         start;
        logic [W-1:0] pat;
        logic [3:0]   reps;
        logic         o, valid, busy, done;
        int           free_edge = 0;
        logic         final_req = 1'b0;
        logic         final_done = 1'b0;
        exp_t         q[$];

        pattern_gen #(.W(W), .CW(4), .GAP(GP), .IDLE_LVL(IL)) u_dut (
            .clk   (clk),
            .rst_b (rst_b),
            .start (start),
            .pat   (pat),
            .reps  (reps),
            .o     (o),
            .valid (valid),
            .busy  (busy),
            .done  (done)
        );

        // Reference: a request accepted at edge e yields reps*W bit cycles with
        // GAP idle cycles between repetitions, then one done cycle; the next
        // request can be accepted two edges after the done cycle starts.
        task automatic expect_xfer(input logic [W-1:0] p, input int r, input int e);
            int t = e;
            for (int rr = 0; rr < r; rr++) begin
                for (int b = W - 1; b >= 0; b--) begin
                    q.push_back('{cyc: t, o: p[b], v: 1'b1, b: 1'b1, d: 1'b0});
                    t++;
                end
                if (rr != r - 1) begin
                    for (int k = 0; k < GP; k++) begin
                        q.push_back('{cyc: t, o: IL, v: 1'b0, b: 1'b1, d: 1'b0});
                        t++;
                    end
                end
            end
            q.push_back('{cyc: t, o: IL, v: 1'b0, b: 1'b0, d: 1'b1});
            free_edge = t + 2;
        endtask

        task automatic drive(input logic s, input logic [W-1:0] p, input logic [3:0] r);
            @(negedge clk);
            start = s;
            pat   = p;
            reps  = r;
            if (s && (r != 4'd0) && (ecnt + 1 >= free_edge)) begin
                expect_xfer(p, int'(r), ecnt + 1);
            end
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 200 && (ecnt + 1 < free_edge); i++) begin
                drive(1'b0, W'($urandom), 4'($urandom));
            end
        endtask

        initial begin
            logic [W-1:0] p1, p2, p3;
            p1 = W'((g == 1) ? 'hA5 : 'h6);
            p2 = W'((g == 1) ? 'h81 : 'h8);
            rst_b = 1'b0;
            start = 1'b0;
            pat   = '0;
            reps  = '0;
            @(negedge clk);
            #2 rst_b = 1'b1;
            repeat (5) drive(1'b0, '0, 4'd0);

            // single repetition
            drive(1'b1, p1, 4'd1);
            drive(1'b0, '0, 4'd0);
            wait_idle();
            // three repetitions
            drive(1'b1, p2, 4'd3);
            drive(1'b0, '0, 4'd0);
            wait_idle();
            // two repetitions of p1 (contiguous for GAP=0)
            drive(1'b1, p1, 4'd2);
            drive(1'b0, '0, 4'd0);
            wait_idle();
            // reps==0 is ignored
            drive(1'b1, p2, 4'd0);
            drive(1'b1, p1, 4'd0);
            repeat (3) drive(1'b0, '0, 4'd0);
            // start held high with changing pat/reps: ignored while busy,
            // re-accepted on the first IDLE cycle after done
            drive(1'b1, p2, 4'd2);
            for (int i = 0; i < 40; i++) begin
                p3 = W'($urandom);
                drive(1'b1, p3, 4'($urandom_range(1, 3)));
            end
            drive(1'b0, '0, 4'd0);
            wait_idle();

            for (int i = 0; i < 300; i++) begin
                drive($urandom_range(0, 2) == 0, W'($urandom), 4'($urandom_range(0, 3)));
            end
            drive(1'b0, '0, 4'd0);
            wait_idle();

            // reset in the middle of SEND: abort, no done pulse
            drive(1'b1, p1, 4'd2);
            drive(1'b0, '0, 4'd0);
            @(posedge clk);
            #1 rst_b = 1'b0;
            free_edge = 0;
            @(negedge clk);
            @(negedge clk);
            #2 rst_b = 1'b1;
            repeat (12) drive(1'b0, '0, 4'd0);

            drive(1'b1, p2, 4'd1);
            drive(1'b0, '0, 4'd0);
            wait_idle();
            repeat (3) drive(1'b0, '0, 4'd0);
            @(negedge clk);
            final_req = 1'b1;
        end

        always @(negedge clk) begin
            if (!rst_b) begin
                check("reset_outputs", g, {o, valid, busy, done}, {IL, 3'b000});
                q.delete();
            end else if (busy || done) begin
                if (q.size() == 0) begin
                    check("unexpected_output", g, {busy, done}, 2'b00);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("trace", g, {ecnt, o, valid, busy, done}, {x.cyc, x.o, x.v, x.b, x.d});
                end
            end else begin
                check("idle_level", g, {o, valid}, {IL, 1'b0});
                if (q.size() != 0) begin
                    check("late_start", g, 64'(q[0].cyc > ecnt), 64'd1);
                end
            end
            if (final_req && !final_done) begin
                check("queue_drained", g, 64'(q.size()), 64'd0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (cfg[0].final_done && cfg[1].final_done && cfg[2].final_done) break;
        end
        if (!(cfg[0].final_done && cfg[1].final_done && cfg[2].final_done)) begin
            $display("FAIL timeout actual=not_finished expected=finished checks=%0d", checks);
            $fatal(1, "bench did not complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
